// File: rtl/rx_byte_fifo_flow.sv
// Receive-side byte buffer between the serial receiver and the data arbiter.
// Bytes are queued in a circular FIFO and leave as single-cycle doutValid
// pulses separated by at least GAP idle cycles. Fill-level hysteresis drives
// XOFF/XON bytes towards the serial transmitter to pace the remote sender.
module rx_byte_fifo_flow #(
    parameter int DEPTH    = 16,
    parameter int AW       = 4,
    parameter int HI_WATER = 12,
    parameter int LO_WATER = 4,
    parameter int GAP      = 2
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic [7:0]    din,
    input  logic          dinValid,
    output logic [7:0]    dout,
    output logic          doutValid,
    input  logic          downstreamBusy,
    output logic [AW:0]   count,
    output logic          overflow,
    input  logic          overflowClr,
    output logic [7:0]    flowTxData,
    output logic          flowTxValid,
    input  logic          flowTxBusy
);

    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0] HI_COUNT   = (AW + 1)'(HI_WATER);
    localparam logic [AW:0] LO_COUNT   = (AW + 1)'(LO_WATER);
    // The EMIT cycle and the IDLE decision cycle each absorb one idle cycle,
    // so GAPW only has to cover the remaining GAP-2 cycles.
    localparam logic [3:0]  GAP_LOAD   = (GAP >= 2) ? 4'(GAP - 2) : 4'd0;
    localparam logic [7:0]  XOFF_BYTE  = 8'h13;
    localparam logic [7:0]  XON_BYTE   = 8'h11;

    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        GAPW
    } emitStateT;

    emitStateT     emitState;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wrPtr;
    logic [AW-1:0] rdPtr;
    logic [3:0]    gapCnt;
    logic          xoffSent;
    logic          wrEn;
    logic          drop;
    logic          launch;

    // Accept, drop and emit-launch decisions, all taken from the registered count.
    // NOTE: every signal is assigned on every path through always_comb, so no latch can be inferred.
    always_comb begin
        wrEn   = dinValid && (count != FULL_COUNT);
        drop   = dinValid && (count == FULL_COUNT);
        launch = ((emitState == IDLE) || ((emitState == EMIT) && (GAP == 0)))
                 && (count != '0) && !downstreamBusy;
    end

    // Byte storage.
    // NOTE: the RAM has no reset; stale contents are never read because the count gates every pop.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wrPtr] <= din;
        end
    end

    // Pointers, fill level and sticky overflow flag.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wrEn) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (launch) begin
                rdPtr <= rdPtr + 1'b1;
            end
            count <= count + {{AW{1'b0}}, wrEn} - {{AW{1'b0}}, launch};
            if (drop) begin
                overflow <= 1'b1;
            end else if (overflowClr) begin
                overflow <= 1'b0;
            end
        end
    end

    // Emit FSM: launches one byte per pulse, then enforces the idle gap.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            emitState <= IDLE;
            gapCnt    <= '0;
            dout      <= 8'h00;
            doutValid <= 1'b0;
        end else if (launch) begin
            emitState <= EMIT;
            dout      <= mem[rdPtr];
            doutValid <= 1'b1;
        end else begin
            doutValid <= 1'b0;
            case (emitState)
                EMIT: begin
                    if (GAP <= 1) begin
                        emitState <= IDLE;
                    end else begin
                        emitState <= GAPW;
                        gapCnt    <= GAP_LOAD;
                    end
                end
                GAPW: begin
                    if (gapCnt == '0) begin
                        emitState <= IDLE;
                    end else begin
                        gapCnt <= gapCnt - 1'b1;
                    end
                end
                default: emitState <= IDLE;
            endcase
        end
    end

    // Flow FSM: one XOFF per crossing of the high mark, one XON per return to the low mark.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            xoffSent    <= 1'b0;
            flowTxValid <= 1'b0;
            flowTxData  <= 8'h00;
        end else begin
            flowTxValid <= 1'b0;
            if (!flowTxBusy) begin
                if (!xoffSent && (count >= HI_COUNT)) begin
                    flowTxValid <= 1'b1;
                    flowTxData  <= XOFF_BYTE;
                    xoffSent    <= 1'b1;
                end else if (xoffSent && (count <= LO_COUNT)) begin
                    flowTxValid <= 1'b1;
                    flowTxData  <= XON_BYTE;
                    xoffSent    <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_rx_byte_fifo_flow.sv
// Self-checking bench for rx_byte_fifo_flow: directed steps with randomized
// data, checked every cycle against a queue-based reference model.
module tb_rx_byte_fifo_flow;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int HI    = 12;
    localparam int LO    = 4;
    localparam int GAP   = 2;

    logic          clk = 1'b0;
    logic          resetn;
    logic [7:0]    din;
    logic          dinValid;
    logic [7:0]    dout;
    logic          doutValid;
    logic          downstreamBusy;
    logic [AW:0]   count;
    logic          overflow;
    logic          overflowClr;
    logic [7:0]    flowTxData;
    logic          flowTxValid;
    logic          flowTxBusy;

    rx_byte_fifo_flow #(
        .DEPTH(DEPTH), .AW(AW), .HI_WATER(HI), .LO_WATER(LO), .GAP(GAP)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .din(din),
        .dinValid(dinValid),
        .dout(dout),
        .doutValid(doutValid),
        .downstreamBusy(downstreamBusy),
        .count(count),
        .overflow(overflow),
        .overflowClr(overflowClr),
        .flowTxData(flowTxData),
        .flowTxValid(flowTxValid),
        .flowTxBusy(flowTxBusy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Inputs as seen by the DUT at each rising edge.
    int         cyc = 0;
    logic       capValid, capBusy, capFbusy, capClr, capResetn;
    logic [7:0] capDin;

    always @(posedge clk) begin
        cyc++;
        capValid  = dinValid;
        capDin    = din;
        capBusy   = downstreamBusy;
        capFbusy  = flowTxBusy;
        capClr    = overflowClr;
        capResetn = resetn;
    end

    // Reference model: a byte queue, a sticky drop flag and an XOFF-sent flag.
    logic [7:0] expQ[$];
    bit         ov;
    bit         xs;
    bit         expF;
    bit         dropped;
    int         cPrev;
    int         sinceLast = 100;
    int         pulseCyc[$];
    logic [7:0] pulseData[$];
    int         xoffCnt = 0;
    int         xonCnt  = 0;

    always @(negedge clk) begin
        if (!resetn) begin
            expQ.delete();
            ov        = 1'b0;
            xs        = 1'b0;
            sinceLast = 100;
            check("rst_count", 32'(count), 0);
            check("rst_doutValid", 32'(doutValid), 0);
            check("rst_flowTxValid", 32'(flowTxValid), 0);
            check("rst_overflow", 32'(overflow), 0);
        end else if (capResetn) begin
            cPrev   = expQ.size();
            dropped = 1'b0;
            sinceLast++;
            if (doutValid) begin
                check("pop_nonempty", 32'(expQ.size() > 0), 1);
                check("pop_not_busy", 32'(capBusy), 0);
                check("gap_spacing", 32'(sinceLast >= GAP + 1), 1);
                if (expQ.size() > 0) begin
                    check("dout_data", 32'(dout), 32'(expQ[0]));
                    void'(expQ.pop_front());
                end
                pulseCyc.push_back(cyc);
                pulseData.push_back(dout);
                sinceLast = 0;
            end
            if (capValid) begin
                if (cPrev == DEPTH) dropped = 1'b1;
                else expQ.push_back(capDin);
            end
            ov   = dropped ? 1'b1 : (capClr ? 1'b0 : ov);
            expF = !capFbusy && ((!xs && cPrev >= HI) || (xs && cPrev <= LO));
            check("flow_valid", 32'(flowTxValid), 32'(expF));
            if (expF) begin
                check("flow_data", 32'(flowTxData), xs ? 32'h11 : 32'h13);
                xs = !xs;
            end
            if (flowTxValid) begin
                if (flowTxData == 8'h13) xoffCnt++;
                else if (flowTxData == 8'h11) xonCnt++;
            end
            check("count", 32'(count), 32'(expQ.size()));
            check("overflow", 32'(overflow), 32'(ov));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic writeByte(input logic [7:0] b);
        din      = b;
        dinValid = 1'b1;
        tick();
        dinValid = 1'b0;
    endtask

    int base;
    int w0;
    int x0;
    int n0;
    int sent;

    initial begin
        resetn         = 1'b0;
        din            = 8'h00;
        dinValid       = 1'b0;
        downstreamBusy = 1'b0;
        overflowClr    = 1'b0;
        flowTxBusy     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_dout", 32'(dout), 0);
        check("rst_flowTxData", 32'(flowTxData), 0);
        tick();
        resetn = 1'b1;
        tick();

        // Order, latency and gap.
        base = pulseCyc.size();
        w0   = cyc;
        writeByte(8'h41);
        writeByte(8'h42);
        writeByte(8'h43);
        repeat (15) tick();
        check("t1_pulses", 32'(pulseCyc.size() - base), 3);
        if (pulseCyc.size() - base == 3) begin
            check("t1_latency", 32'(pulseCyc[base] - w0), 2);
            check("t1_space01", 32'(pulseCyc[base + 1] - pulseCyc[base]), 3);
            check("t1_space12", 32'(pulseCyc[base + 2] - pulseCyc[base + 1]), 3);
            for (int i = 0; i < 3; i++) check("t1_data", 32'(pulseData[base + i]), 32'h41 + 32'(i));
        end
        check("t1_count", 32'(count), 0);

        // Stall while downstream is busy, then release.
        downstreamBusy = 1'b1;
        base = pulseCyc.size();
        repeat (5) writeByte(8'($urandom));
        repeat (6) tick();
        check("t2_stall_pulses", 32'(pulseCyc.size() - base), 0);
        check("t2_stall_count", 32'(count), 5);
        downstreamBusy = 1'b0;
        repeat (20) tick();
        check("t2_release_pulses", 32'(pulseCyc.size() - base), 5);
        check("t2_count", 32'(count), 0);

        // Overflow on the 17th byte, then clear.
        downstreamBusy = 1'b1;
        repeat (17) writeByte(8'($urandom));
        repeat (2) tick();
        check("t3_count_full", 32'(count), 16);
        check("t3_overflow_set", 32'(overflow), 1);
        overflowClr = 1'b1;
        tick();
        overflowClr = 1'b0;
        tick();
        check("t3_overflow_clr", 32'(overflow), 0);
        base = pulseCyc.size();
        downstreamBusy = 1'b0;
        repeat (60) tick();
        check("t3_drain_pulses", 32'(pulseCyc.size() - base), 16);
        check("t3_drain_count", 32'(count), 0);

        // XOFF at the high mark, no repeat, single XON at the low mark.
        x0 = xoffCnt;
        n0 = xonCnt;
        downstreamBusy = 1'b1;
        repeat (12) writeByte(8'($urandom));
        repeat (3) tick();
        check("t4_xoff_once", 32'(xoffCnt - x0), 1);
        check("t4_xoff_data", 32'(flowTxData), 32'h13);
        repeat (2) writeByte(8'($urandom));
        repeat (3) tick();
        check("t4_xoff_no_repeat", 32'(xoffCnt - x0), 1);
        check("t4_no_early_xon", 32'(xonCnt - n0), 0);
        downstreamBusy = 1'b0;
        for (int i = 0; i < 100 && count > 4; i++) tick();
        check("t4_reach_lo", 32'(count), 4);
        repeat (3) tick();
        check("t4_xon_once", 32'(xonCnt - n0), 1);
        check("t4_xon_data", 32'(flowTxData), 32'h11);
        repeat (30) tick();
        check("t4_xon_no_repeat", 32'(xonCnt - n0), 1);
        check("t4_count", 32'(count), 0);

        // Flow request held while the transmitter is busy.
        x0 = xoffCnt;
        flowTxBusy     = 1'b1;
        downstreamBusy = 1'b1;
        repeat (12) writeByte(8'($urandom));
        repeat (4) tick();
        check("t5_held_no_strobe", 32'(xoffCnt - x0), 0);
        flowTxBusy = 1'b0;
        tick();
        check("t5_release_valid", 32'(flowTxValid), 1);
        check("t5_release_data", 32'(flowTxData), 32'h13);
        downstreamBusy = 1'b0;
        repeat (50) tick();
        check("t5_count", 32'(count), 0);

        // Random stream of 40 bytes so both pointers wrap.
        sent = 0;
        for (int i = 0; i < 2000 && sent < 40; i++) begin
            dinValid       = ($urandom_range(0, 3) == 0);
            din            = 8'($urandom);
            downstreamBusy = ($urandom_range(0, 7) == 0);
            flowTxBusy     = ($urandom_range(0, 3) == 0);
            tick();
            if (dinValid) sent++;
        end
        dinValid       = 1'b0;
        downstreamBusy = 1'b0;
        flowTxBusy     = 1'b0;
        repeat (60) tick();
        check("t6_sent", 32'(sent), 40);
        check("t6_count", 32'(count), 0);
        check("t6_all_emitted", 32'(expQ.size()), 0);

        // Asynchronous reset with bytes buffered.
        downstreamBusy = 1'b1;
        repeat (7) writeByte(8'($urandom));
        tick();
        check("t7_pre_count", 32'(count), 7);
        @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check("t7_async_count", 32'(count), 0);
        check("t7_async_doutValid", 32'(doutValid), 0);
        check("t7_async_flowTxValid", 32'(flowTxValid), 0);
        tick();
        resetn = 1'b1;
        downstreamBusy = 1'b0;
        base = pulseCyc.size();
        n0   = xonCnt;
        repeat (20) tick();
        check("t7_no_pulses", 32'(pulseCyc.size() - base), 0);
        check("t7_no_xon", 32'(xonCnt - n0), 0);
        check("t7_count", 32'(count), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
